// File: rtl/crono_pkg.sv
// Shared stopwatch types: run-control state encoding, button pulse priority
// and the prescaler width helper.
package crono_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StLap   = 2'b11
  } state_e;

  // Bit positions in the pulse vector; a higher index wins.
  localparam int unsigned PrioLap = 0;
  localparam int unsigned PrioSs  = 1;
  localparam int unsigned PrioClr = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned crono_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Keep only the highest-priority pulse of the cycle.
  function automatic logic [2:0] prio_pick(input logic [2:0] p);
    logic [2:0] win;
    win = '0;
    if (p[PrioClr])     win[PrioClr] = 1'b1;
    else if (p[PrioSs]) win[PrioSs]  = 1'b1;
    else                win[PrioLap] = p[PrioLap];
    return win;
  endfunction

endpackage

// File: rtl/crono_ctrl_if.sv
// Button/datapath-side signal bundle of the stopwatch run-control sequencer.
interface crono_ctrl_if;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic       at_max;
  logic       tick_en;
  logic       cnt_clr;
  logic       freeze;
  logic [1:0] state;
  logic       run_led;

  modport master (
    output btn_ss, btn_lap, btn_clr, at_max,
    input  tick_en, cnt_clr, freeze, state, run_led
  );

  modport slave (
    input  btn_ss, btn_lap, btn_clr, at_max,
    output tick_en, cnt_clr, freeze, state, run_led
  );
endinterface

// File: rtl/crono_btn_sync.sv
// Two-flop synchronizer plus rising-edge detector: one pulse per press.
module crono_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= sync_q[1];
    end
  end

  assign pulse_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/crono_ctrl.sv
// Stopwatch run-control FSM and one-per-second prescaler.
// Define CRONO_LAP_EN to build the LAP state, lap button and display freeze.
module crono_ctrl
  import crono_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input logic         clk,
  input logic         rst_n,
  crono_ctrl_if.slave bus
);

  localparam int unsigned   Div   = CLK_HZ / TICK_HZ;
  localparam int unsigned   PsW   = crono_width(Div);
  localparam logic [PsW-1:0] PsMax = PsW'(Div - 1);

  logic       ss_p, clr_p, lap_p;
  logic [2:0] raw, win;

  crono_btn_sync u_sync_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (bus.btn_ss),
    .pulse_o(ss_p)
  );

  crono_btn_sync u_sync_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (bus.btn_clr),
    .pulse_o(clr_p)
  );

`ifdef CRONO_LAP_EN
  crono_btn_sync u_sync_lap (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (bus.btn_lap),
    .pulse_o(lap_p)
  );
`else
  logic unused_lap;
  assign lap_p      = 1'b0;
  assign unused_lap = bus.btn_lap;
`endif

  always_comb begin
    raw          = '0;
    raw[PrioClr] = clr_p;
    raw[PrioSs]  = ss_p;
    raw[PrioLap] = lap_p;
  end

  assign win = prio_pick(raw);

  state_e         state_q, state_d;
  logic [PsW-1:0] ps_q, ps_d;
  logic           cnt_clr_q, run_led_q;
  logic           running, wrap;

`ifdef CRONO_LAP_EN
  assign running = (state_q == StRun) || (state_q == StLap);
`else
  assign running = (state_q == StRun);
`endif
  assign wrap        = running && (ps_q == PsMax);
  assign bus.tick_en = wrap && !bus.at_max;

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    if (win[PrioClr]) begin
      state_d = StIdle;
      ps_d    = '0;
    end else begin
      case (state_q)
`ifdef CRONO_LAP_EN
        StRun, StLap: begin
`else
        StRun: begin
`endif
          ps_d = wrap ? '0 : ps_q + 1'b1;
          // Saturation at 59:59 parks the watch instead of issuing the tick.
          if (wrap && bus.at_max)  state_d = StPause;
          else if (win[PrioSs])    state_d = StPause;
          else if (win[PrioLap])   state_d = (state_q == StLap) ? StRun : StLap;
        end
        StPause: begin
          if (win[PrioSs] && !bus.at_max) state_d = StRun;
        end
        default: begin
          ps_d = '0;
          if (win[PrioSs]) state_d = StRun;
        end
      endcase
    end
  end

`ifdef CRONO_LAP_EN
  logic freeze_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ps_q      <= '0;
      cnt_clr_q <= 1'b0;
      run_led_q <= 1'b0;
`ifdef CRONO_LAP_EN
      freeze_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      cnt_clr_q <= win[PrioClr];
      run_led_q <= (state_d == StRun) || (state_d == StLap);
`ifdef CRONO_LAP_EN
      freeze_q  <= (state_d == StLap);
`endif
    end
  end

  assign bus.state   = state_q;
  assign bus.cnt_clr = cnt_clr_q;
  assign bus.run_led = run_led_q;
`ifdef CRONO_LAP_EN
  assign bus.freeze  = freeze_q;
`else
  assign bus.freeze  = 1'b0;
`endif

endmodule

// File: tb/tb_crono_ctrl.sv
// Self-checking bench for crono_ctrl (DIV=4) against a cycle-level behavioural model.
module tb_crono_ctrl;

  localparam int Div = 4;
`ifdef CRONO_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   rst_lvl = 1'b0;
  bit   am_lvl  = 1'b0;

  crono_ctrl_if bus ();

  crono_ctrl #(
    .CLK_HZ (4),
    .TICK_HZ(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: mode 0=idle 1=run 2=pause 3=lap; sub = cycles into the current second.
  int m_mode, m_sub, m_clr;
  int h_ss, h_lap, h_clr;  // bit i = level sampled i+1 edges ago
  int tick_seen;

  function automatic void m_reset();
    m_mode = 0; m_sub = 0; m_clr = 0;
    h_ss = 0; h_lap = 0; h_clr = 0;
  endfunction

  function automatic bit pressed(input int h);
    return h[1] && !h[2];
  endfunction

  function automatic bit m_running();
    return (m_mode == 1) || (m_mode == 3);
  endfunction

  function automatic void model_edge();
    bit pc, ps, pl, wrap;
    pc = pressed(h_clr);
    ps = pressed(h_ss) && !pc;
    pl = pressed(h_lap) && LapEn && !pc && !ps;
    wrap = m_running() && (m_sub == Div - 1);
    m_clr = int'(pc);
    if (pc) begin
      m_mode = 0;
      m_sub  = 0;
    end else if (m_running()) begin
      m_sub = (m_sub + 1) % Div;
      if (wrap && bus.at_max) m_mode = 2;
      else if (ps)            m_mode = 2;
      else if (pl)            m_mode = (m_mode == 3) ? 1 : 3;
    end else if (m_mode == 2) begin
      if (ps && !bus.at_max) m_mode = 1;
    end else begin
      m_sub = 0;
      if (ps) m_mode = 1;
    end
    h_ss  = ((h_ss  << 1) | int'(bus.btn_ss))  & 7;
    h_lap = ((h_lap << 1) | int'(bus.btn_lap)) & 7;
    h_clr = ((h_clr << 1) | int'(bus.btn_clr)) & 7;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit tick_exp;
    tick_exp = m_running() && (m_sub == Div - 1) && !bus.at_max;
    chk({tag, ":state"},   8'(bus.state),   8'(m_mode));
    chk({tag, ":tick"},    8'(bus.tick_en), 8'(tick_exp));
    chk({tag, ":cnt_clr"}, 8'(bus.cnt_clr), 8'(m_clr));
    chk({tag, ":freeze"},  8'(bus.freeze),  8'(m_mode == 3));
    chk({tag, ":run_led"}, 8'(bus.run_led), 8'(m_running()));
    if (bus.tick_en === 1'b1) tick_seen++;
  endtask

  task automatic step(input string tag, input bit ss, input bit lap, input bit clr);
    @(negedge clk);
    rst_n       = rst_lvl;
    bus.btn_ss  = ss;
    bus.btn_lap = lap;
    bus.btn_clr = clr;
    bus.at_max  = am_lvl;
    @(posedge clk);
    if (!rst_n) m_reset();
    else        model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input string tag, input bit ss, input bit lap, input bit clr);
    for (int i = 0; i < 3; i++) step(tag, ss, lap, clr);
    step(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_lvl = 1'b0;
    rst_n   = 1'b0;
    #1;
    m_reset();
    check_all(tag);
  endtask

  bit r_ss, r_lap, r_clr;

  initial begin
    bus.btn_ss = 1'b0; bus.btn_lap = 1'b0; bus.btn_clr = 1'b0; bus.at_max = 1'b0;
    m_reset();
    tick_seen = 0;

    // Reset held while buttons toggle, then released with buttons low
    for (int i = 0; i < 6; i++) step("rst_hold", i[0], !i[0], i[1]);
    rst_lvl = 1'b1;
    idle("rst_rel", 4);

    // Start, then three whole seconds of ticks
    press("start", 1'b1, 1'b0, 1'b0);
    tick_seen = 0;
    idle("run", 12);
    chk("run_tick_count", 8'(tick_seen), 8'd3);

    // Pause with two cycles of the second already elapsed, then resume
    for (int i = 0; i < 8 && m_sub != 3; i++) step("align", 1'b0, 1'b0, 1'b0);
    press("pause", 1'b1, 1'b0, 1'b0);
    chk("paused", 8'(bus.state), 8'd2);
    idle("pause_hold", 20);
    press("resume", 1'b1, 1'b0, 1'b0);
    idle("resume_run", 8);

    // Lap in and out; without the lap build the button must be ignored
    press("lap_in", 1'b0, 1'b1, 1'b0);
    tick_seen = 0;
    idle("lap_run", 8);
    chk("lap_tick_count", 8'(tick_seen), 8'd2);
    press("lap_out", 1'b0, 1'b1, 1'b0);
    idle("lap_after", 3);
    press("lap_again", 1'b0, 1'b1, 1'b0);

    // All three buttons in the same cycle: clear wins
    press("all3", 1'b1, 1'b1, 1'b1);
    chk("all3_idle", 8'(bus.state), 8'd0);
    idle("all3_after", 3);
    press("restart", 1'b1, 1'b0, 1'b0);
    idle("restart_run", 6);

    // Saturation at 59:59
    am_lvl = 1'b1;
    idle("sat_run", 6);
    chk("sat_paused", 8'(bus.state), 8'd2);
    press("sat_ss", 1'b1, 1'b0, 1'b0);
    chk("sat_stays", 8'(bus.state), 8'd2);
    press("sat_clr", 1'b0, 1'b0, 1'b1);
    chk("sat_idle", 8'(bus.state), 8'd0);
    am_lvl = 1'b0;
    idle("sat_after", 3);

    // Mid-operation asynchronous reset
    press("pre_arst", 1'b1, 1'b0, 1'b0);
    idle("pre_arst_run", 3);
    async_reset("arst");
    idle("arst_hold", 2);
    rst_lvl = 1'b1;
    idle("arst_rel", 3);

    // Randomized button/at_max activity with occasional resets
    r_ss = 1'b0; r_lap = 1'b0; r_clr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) r_ss  = !r_ss;
      if ($urandom_range(0, 6) == 0) r_lap = !r_lap;
      if ($urandom_range(0, 19) == 0) r_clr = !r_clr;
      if ($urandom_range(0, 24) == 0) am_lvl = !am_lvl;
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rnd_arst");
        idle("rnd_arst_hold", 2);
        rst_lvl = 1'b1;
      end
      step("rnd", r_ss, r_lap, r_clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
